// File: rtl/inmux_ctrl_pkg.sv
// Shared types, default parameters and helpers for the inmux_ctrl_n controller.
package inmux_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_SEL_W = 2;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_ERR_W = 8;

    function automatic logic sel_is_valid(input int unsigned sel, input int unsigned n_ch);
        return sel < n_ch;
    endfunction

endpackage

// File: rtl/inmux_ctrl_n_if.sv
// Token-stream bundle of inmux_ctrl_n: producer channels, control channel, downstream side and status.
// slave = the controller, master = the surrounding producers/consumer.
interface inmux_ctrl_n_if
    import inmux_ctrl_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = DEF_SEL_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int ERR_W = DEF_ERR_W
) ();

    logic [N_CH-1:0]  t_k_req;
    logic [N_CH-1:0]  t_k_ack;
    logic             t_c_req;
    logic [SEL_W-1:0] t_c_sel;
    logic [LEN_W-1:0] t_c_len;
    logic             t_c_ack;
    logic             i_inmux_req;
    logic             i_inmux_ack;
    logic [SEL_W-1:0] i_inmux_sel;
    logic             i_inmux_last;
    logic             cap_en;
    logic             busy;
    logic [ERR_W-1:0] err_cnt;

    modport slave (
        input  t_k_req, t_c_req, t_c_sel, t_c_len, i_inmux_ack,
        output t_k_ack, t_c_ack, i_inmux_req, i_inmux_sel, i_inmux_last,
               cap_en, busy, err_cnt
    );

    modport master (
        output t_k_req, t_c_req, t_c_sel, t_c_len, i_inmux_ack,
        input  t_k_ack, t_c_ack, i_inmux_req, i_inmux_sel, i_inmux_last,
               cap_en, busy, err_cnt
    );

endinterface

// File: rtl/inmux_out_reg.sv
// One-entry req/ack output register holding the downstream token's source select and last flag.
module inmux_out_reg #(
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             last_i,
    input  logic             ack_i,
    output logic             full_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             last_o
);

    logic             full_q, full_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             last_q, last_d;

    // A load in the same cycle as a drain keeps the entry full: 1 beat per cycle.
    always_comb begin
        full_d = full_q;
        sel_d  = sel_q;
        last_d = last_q;
        if (load_i) begin
            full_d = 1'b1;
            sel_d  = sel_i;
            last_d = last_i;
        end else if (full_q && ack_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            sel_q  <= '0;
            last_q <= 1'b0;
        end else begin
            full_q <= full_d;
            sel_q  <= sel_d;
            last_q <= last_d;
        end
    end

    assign full_o = full_q;
    assign sel_o  = sel_q;
    assign last_o = last_q;

endmodule

// File: rtl/inmux_ctrl_n.sv
// N:1 input-mux controller: a (sel, len) control token forwards len+1 beats of one channel downstream.
// Define INMUX_CTRL_OUT_REG_EN for a registered downstream side; default is combinational pass-through.
module inmux_ctrl_n
    import inmux_ctrl_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = DEF_SEL_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic          clk,
    input  logic          reset_n,
    inmux_ctrl_n_if.slave bus
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [N_CH-1:0]  ch_hit;
    logic             run;
    logic             req_sel;
    logic             ctl_valid;
    logic             ctl_bad;
    logic             last_beat;
    logic             in_ack_en;
    logic             in_xfer;
    logic             full;

    always_comb begin
        ch_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_hit[i] = (cur_sel_q == SEL_W'(i));
        end
    end

    // Gating with reset_n keeps every ack and request low while reset is held.
    assign run       = reset_n && (state_q == RUN);
    assign req_sel   = |(bus.t_k_req & ch_hit);
    assign ctl_valid = sel_is_valid(32'(bus.t_c_sel), N_CH);
    assign ctl_bad   = reset_n && (state_q == IDLE) && bus.t_c_req && !ctl_valid;
    assign last_beat = (rem_q == '0);

`ifdef INMUX_CTRL_OUT_REG_EN
    assign in_ack_en = run && (!full || bus.i_inmux_ack);
    assign in_xfer   = in_ack_en && req_sel;

    inmux_out_reg #(.SEL_W(SEL_W)) u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (in_xfer),
        .sel_i   (cur_sel_q),
        .last_i  (last_beat),
        .ack_i   (bus.i_inmux_ack),
        .full_o  (full),
        .sel_o   (bus.i_inmux_sel),
        .last_o  (bus.i_inmux_last)
    );

    assign bus.i_inmux_req = reset_n && full;
    assign bus.t_k_ack     = ch_hit & {N_CH{in_xfer}};
`else
    assign full      = 1'b0;
    assign in_ack_en = run && bus.i_inmux_ack;
    assign in_xfer   = in_ack_en && req_sel;

    assign bus.i_inmux_req  = run && req_sel;
    assign bus.i_inmux_sel  = cur_sel_q;
    assign bus.i_inmux_last = run && last_beat;
    assign bus.t_k_ack      = ch_hit & {N_CH{in_ack_en}};
`endif

    assign bus.cap_en  = in_xfer;
    assign bus.busy    = run || full;
    assign bus.t_c_ack = ctl_bad || (in_xfer && last_beat);
    assign bus.err_cnt = err_cnt_q;

    // NOTE: every variable gets its hold value first so no branch can infer a latch.
    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        rem_d     = rem_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.t_c_req && ctl_valid) begin
                    state_d   = RUN;
                    cur_sel_d = bus.t_c_sel;
                    rem_d     = bus.t_c_len;
                end
            end
            RUN: begin
                if (in_xfer) begin
                    if (last_beat) state_d = IDLE;
                    else           rem_d   = rem_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (ctl_bad && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous, sampled on clk.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
            rem_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            rem_q     <= rem_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule
